// File: rtl/i2s_master_ctrl_if.sv
// i2s_master_ctrl_if: sample-side handshake and codec pin bundle for the I2S master.
// The I2S_UNDERRUN_CNT_EN build adds clr_cnt/underrun_cnt.
interface i2s_master_ctrl_if #(
    parameter int WL = 32
);
    logic          en;
    logic [WL-1:0] tx_left, tx_right;
    logic          tx_valid, tx_ready;
    logic [WL-1:0] rx_left, rx_right;
    logic          rx_valid, underrun;
    logic          aud_bclk, aud_lrc, aud_dacdat, aud_adcdat;
`ifdef I2S_UNDERRUN_CNT_EN
    logic          clr_cnt;
    logic [15:0]   underrun_cnt;
`endif
    modport master(
        input  en, tx_left, tx_right, tx_valid, aud_adcdat,
`ifdef I2S_UNDERRUN_CNT_EN
        input  clr_cnt,
        output underrun_cnt,
`endif
        output tx_ready, rx_left, rx_right, rx_valid, underrun,
        output aud_bclk, aud_lrc, aud_dacdat
    );
    modport slave(
        output en, tx_left, tx_right, tx_valid, aud_adcdat,
`ifdef I2S_UNDERRUN_CNT_EN
        output clr_cnt,
        input  underrun_cnt,
`endif
        input  tx_ready, rx_left, rx_right, rx_valid, underrun,
        input  aud_bclk, aud_lrc, aud_dacdat
    );
endinterface

// File: rtl/i2s_master_ctrl.sv
// i2s_master_ctrl: I2S master generating BCLK/LRCK, serializing stereo TX and deserializing stereo RX.
// Defining I2S_UNDERRUN_CNT_EN adds a saturating underrun counter with clear.
module i2s_master_ctrl #(
    parameter int CLK_DIV = 8,
    parameter int WL      = 32
) (
    input logic               clk,
    input logic               rst,
    i2s_master_ctrl_if.master bus
);
    logic [7:0]    div_cnt_q, div_cnt_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d, p_rx;
    logic          bclk_q, bclk_d, lrc_q, lrc_d, dac_q, dac_d, seen_q, seen_d;
    logic          hold_full_q, hold_full_d, rx_valid_q, rx_valid_d, underrun_q, underrun_d;
    logic [WL-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d, frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic [WL-1:0] rx_sh_l_q, rx_sh_l_d, rx_sh_r_q, rx_sh_r_d, rx_left_q, rx_left_d, rx_right_q, rx_right_d;
    logic [31:0]   tx_w32, hold_w32;
    logic          wrap, rise, fall, load, take, rx_keep, frame_done;

    always_comb begin
        wrap       = div_cnt_q == 8'(CLK_DIV - 1);
        rise       = bus.en & wrap & ~bclk_q;
        fall       = bus.en & wrap & bclk_q;
        load       = fall & (bit_cnt_q == 6'd0);
        take       = bus.tx_valid & ~hold_full_q;
        p_rx       = bit_cnt_q - 6'd1;
        rx_keep    = {1'b0, p_rx[4:0]} < 6'(WL);
        frame_done = rise & (bit_cnt_q == 6'd0) & seen_q;
        // Left-justify words in the 32-bit slot so slot bits past WL read as zero
        tx_w32     = 32'(bit_cnt_q[5] ? frame_r_q : frame_l_q) << (32 - WL);
        hold_w32   = 32'(hold_l_q) << (32 - WL);
        div_cnt_d  = ~bus.en ? 8'd0 : wrap ? 8'd0 : div_cnt_q + 8'd1;
        bclk_d     = bus.en & (bclk_q ^ wrap);
        bit_cnt_d  = ~bus.en ? 6'd0 : bit_cnt_q + {5'd0, fall};
        lrc_d      = ~bus.en ? 1'b0 : fall ? bit_cnt_d[5] : lrc_q;
        dac_d      = ~bus.en ? 1'b0 : ~fall ? dac_q :
                     load ? hold_full_q & hold_w32[31] : tx_w32[5'd31 - bit_cnt_q[4:0]];
        seen_d     = bus.en & (seen_q | load);
        hold_full_d = (hold_full_q & ~load) | take;
        hold_l_d   = take ? bus.tx_left : hold_l_q;
        hold_r_d   = take ? bus.tx_right : hold_r_q;
        frame_l_d  = load ? (hold_full_q ? hold_l_q : '0) : frame_l_q;
        frame_r_d  = load ? (hold_full_q ? hold_r_q : '0) : frame_r_q;
        underrun_d = load & ~hold_full_q;
        rx_sh_l_d  = (rise & ~p_rx[5] & rx_keep) ? {rx_sh_l_q[WL-2:0], bus.aud_adcdat} : rx_sh_l_q;
        rx_sh_r_d  = (rise & p_rx[5] & rx_keep) ? {rx_sh_r_q[WL-2:0], bus.aud_adcdat} : rx_sh_r_q;
        rx_left_d  = frame_done ? rx_sh_l_d : rx_left_q;
        rx_right_d = frame_done ? rx_sh_r_d : rx_right_q;
        rx_valid_d = frame_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            lrc_q       <= 1'b0;
            dac_q       <= 1'b0;
            seen_q      <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            frame_l_q   <= '0;
            frame_r_q   <= '0;
            underrun_q  <= 1'b0;
            rx_sh_l_q   <= '0;
            rx_sh_r_q   <= '0;
            rx_left_q   <= '0;
            rx_right_q  <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bclk_q      <= bclk_d;
            lrc_q       <= lrc_d;
            dac_q       <= dac_d;
            seen_q      <= seen_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            frame_l_q   <= frame_l_d;
            frame_r_q   <= frame_r_d;
            underrun_q  <= underrun_d;
            rx_sh_l_q   <= rx_sh_l_d;
            rx_sh_r_q   <= rx_sh_r_d;
            rx_left_q   <= rx_left_d;
            rx_right_q  <= rx_right_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;
    always_comb ucnt_d = bus.clr_cnt ? 16'd0 : (underrun_q && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ucnt_q <= '0;
        else     ucnt_q <= ucnt_d;
    end
    assign bus.underrun_cnt = ucnt_q;
`endif

    assign bus.tx_ready   = ~hold_full_q;
    assign bus.rx_left    = rx_left_q;
    assign bus.rx_right   = rx_right_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.underrun   = underrun_q;
    assign bus.aud_bclk   = bclk_q;
    assign bus.aud_lrc    = lrc_q;
    assign bus.aud_dacdat = dac_q;
endmodule

// File: tb/tb_i2s_master_ctrl.sv
// tb_i2s_master_ctrl: directed loopback bench for i2s_master_ctrl (WL=32/CLK_DIV=8 and WL=24/CLK_DIV=2).
module tb_i2s_master_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;

    i2s_master_ctrl_if #(.WL(32)) ba();
    i2s_master_ctrl_if #(.WL(24)) bb();
    assign ba.aud_adcdat = ba.aud_dacdat;
    assign bb.aud_adcdat = bb.aud_dacdat;

    i2s_master_ctrl #(.CLK_DIV(8), .WL(32)) u_a (.clk(clk), .rst(rst), .bus(ba));
    i2s_master_ctrl #(.CLK_DIV(2), .WL(24)) u_b (.clk(clk), .rst(rst), .bus(bb));

    int          rxa_n = 0, rxa_wide = 0, una_n = 0, una_wide = 0, rxb_n = 0;
    logic [31:0] rxa_l = '0, rxa_r = '0;
    logic        rxa_p = 1'b0, una_p = 1'b0;

    always @(negedge clk) begin
        if (ba.rx_valid) begin
            rxa_n++;
            rxa_l = ba.rx_left;
            rxa_r = ba.rx_right;
        end
        if (ba.rx_valid & rxa_p) rxa_wide++;
        if (ba.underrun) una_n++;
        if (ba.underrun & una_p) una_wide++;
        rxa_p = ba.rx_valid;
        una_p = ba.underrun;
        if (bb.rx_valid) rxb_n++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic rise_bit(input bit s, output logic d, output logic l, output int cyc);
        logic p, c, hit;
        p   = s ? bb.aud_bclk : ba.aud_bclk;
        cyc = 0;
        hit = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            c   = s ? bb.aud_bclk : ba.aud_bclk;
            hit = c & ~p;
            p   = c;
        end while (!hit && cyc < 64);
        if (!hit) chk("bclk_timeout", 0, 1);
        d = s ? bb.aud_dacdat : ba.aud_dacdat;
        l = s ? bb.aud_lrc : ba.aud_lrc;
    endtask

    task automatic send(input bit s, input logic [31:0] l, input logic [31:0] r);
        @(negedge clk);
        if (s) begin
            bb.tx_left  = l[23:0];
            bb.tx_right = r[23:0];
            bb.tx_valid = 1'b1;
        end else begin
            ba.tx_left  = l;
            ba.tx_right = r;
            ba.tx_valid = 1'b1;
        end
        @(negedge clk);
        ba.tx_valid = 1'b0;
        bb.tx_valid = 1'b0;
    endtask

    task automatic frame(input bit s, input bit do_send, input logic [31:0] nl, input logic [31:0] nr,
                         output logic [63:0] d, output logic [63:0] l, output int c);
        logic b, x;
        for (int i = 0; i < 64; i++) begin
            if (i == 1 && do_send) begin
                chk("tx_ready_at_load", s ? bb.tx_ready : ba.tx_ready, 1);
                send(s, nl, nr);
            end
            rise_bit(s, b, x, c);
            d = {d[62:0], b};
            l = {l[62:0], x};
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] tl[3], tr[3];
        logic [63:0] d, l;
        logic        b, x;
        int          c, n0, cyc;
        tl = '{32'hA5A5_0001, 32'h1357_9BDF, 32'hDEAD_BEEF};
        tr = '{32'h5A5A_8000, 32'h2468_ACE0, 32'h0F0F_00FF};
        ba.en = 0; ba.tx_valid = 0; ba.tx_left = '0; ba.tx_right = '0;
        bb.en = 0; bb.tx_valid = 0; bb.tx_left = '0; bb.tx_right = '0;
`ifdef I2S_UNDERRUN_CNT_EN
        ba.clr_cnt = 0; bb.clr_cnt = 0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", ba.tx_ready, 1);
        chk("rst_pins", {ba.aud_bclk, ba.aud_lrc, ba.aud_dacdat}, 0);
        chk("rst_pulses", {ba.rx_valid, ba.underrun}, 0);
        chk("rst_rx", {ba.rx_left, ba.rx_right}, 0);
        chk("rst_b_tx_ready", bb.tx_ready, 1);
        rst = 1'b0;
        send(0, tl[0], tr[0]);
        chk("a_hold_full", ba.tx_ready, 0);
        ba.en = 1'b1;
        rise_bit(0, b, x, c);
        for (int k = 0; k < 5; k++) begin
            frame(0, k < 2, k < 2 ? tl[k+1] : 32'h0, k < 2 ? tr[k+1] : 32'h0, d, l, c);
            repeat (2) @(negedge clk);
            chk("a_dac_frame", d, k < 3 ? {tl[k], tr[k]} : 64'h0);
            chk("a_rx_count", rxa_n, k + 1);
            chk("a_rx_data", {rxa_l, rxa_r}, k < 3 ? {tl[k], tr[k]} : 64'h0);
            chk("a_underruns", una_n, k < 3 ? 0 : k - 2);
            if (k == 0) begin
                chk("a_lrc_pattern", l, 64'h0000_0001_FFFF_FFFE);
                chk("a_bclk_period", c, 16);
            end
        end
        chk("a_rx_pulse_width", rxa_wide, 0);
        chk("a_underrun_width", una_wide, 0);
`ifdef I2S_UNDERRUN_CNT_EN
        chk("a_underrun_cnt", ba.underrun_cnt, 2);
        ba.clr_cnt = 1'b1;
        @(negedge clk);
        ba.clr_cnt = 1'b0;
        chk("a_underrun_cnt_clr", ba.underrun_cnt, 0);
`endif
        rise_bit(0, b, x, c);
        send(0, 32'h1111_1111, 32'h2222_2222);
        chk("a_hold_before_rst", ba.tx_ready, 0);
        for (int i = 1; i < 40; i++) rise_bit(0, b, x, c);
        chk("a_lrc_right_slot", ba.aud_lrc, 1);
        n0 = rxa_n;
        #2 rst = 1'b1;
        #1 chk("a_async_rst", {ba.aud_bclk, ba.aud_lrc, ba.aud_dacdat, ba.rx_valid, ba.underrun, ba.tx_ready}, 6'b000001);
        chk("a_async_rst_rx", {ba.rx_left, ba.rx_right}, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ba.rx_valid && cyc < 3000);
        chk("a_first_rx_after_rst", cyc, 1032);
        repeat (2) @(negedge clk);
        chk("a_rx_count_after_rst", rxa_n, n0 + 1);
        chk("a_rx_data_after_rst", {rxa_l, rxa_r}, 0);
        ba.en = 1'b0;
        send(1, 32'h00FF_FFFF, 32'h0012_3456);
        bb.en = 1'b1;
        rise_bit(1, b, x, c);
        frame(1, 0, 32'h0, 32'h0, d, l, c);
        repeat (2) @(negedge clk);
        chk("b_dac_frame", d, 64'hFFFF_FF00_1234_5600);
        chk("b_rx_left", bb.rx_left, 24'hFF_FFFF);
        chk("b_rx_right", bb.rx_right, 24'h12_3456);
        chk("b_rx_count", rxb_n, 1);
        bb.en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
